// File: rtl/led_logic_seq_if.sv
// ----------------------------------------------------------------------------
// led_logic_seq_if
// Purpose : groups the operand/request and result/response signals of the
//           led_logic_seq gate unit into one bundle.
// Signals : i_a, i_b   operands (WIDTH)
//           i_op       op select for manual mode (3)
//           i_valid    request valid, o_ready request accept
//           i_auto     1 = auto-scan, 0 = manual
//           o_y, o_op  registered result and the op that produced it
//           o_valid    result valid, i_ready downstream accept
//           o_zero     result-is-zero flag (only with LED_ZERO_FLAG_EN)
// Modports: master = stimulus/downstream side, slave = gate unit side.
// Config  : LED_ZERO_FLAG_EN adds o_zero.
// ----------------------------------------------------------------------------
interface led_logic_seq_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic [2:0]       i_op;
  logic             i_valid;
  logic             o_ready;
  logic             i_auto;
  logic [WIDTH-1:0] o_y;
  logic [2:0]       o_op;
  logic             o_valid;
  logic             i_ready;
`ifdef LED_ZERO_FLAG_EN
  logic             o_zero;
`endif

  modport master (
    output i_a, i_b, i_op, i_valid, i_auto, i_ready,
    input  o_ready, o_y, o_op, o_valid
`ifdef LED_ZERO_FLAG_EN
    , input o_zero
`endif
  );

  modport slave (
    input  i_a, i_b, i_op, i_valid, i_auto, i_ready,
    output o_ready, o_y, o_op, o_valid
`ifdef LED_ZERO_FLAG_EN
    , output o_zero
`endif
  );
endinterface

// File: rtl/led_logic_seq.sv
// ----------------------------------------------------------------------------
// led_logic_seq
// Purpose : registered bitwise gate unit driving a WIDTH-bit LED bank.
//           Manual mode computes the selected op under a valid/ready
//           handshake; auto mode steps through all 8 ops, one every DIV clocks.
// Ports   : i_clk  clock, all state on rising edge
//           i_rst  synchronous active-high reset
//           bus    led_logic_seq_if.slave (operands, op, handshakes, result)
// Params  : WIDTH  operand/result width (>=1)
//           DIV    auto-mode dwell per op in clocks (>=1)
// Config  : define LED_ZERO_FLAG_EN to add bus.o_zero, a registered flag set
//           when the loaded result is all zeros.
// Op codes: 0 AND 1 NAND 2 OR 3 NOR 4 XOR 5 XNOR 6 INV(~a) 7 PASS(a)
// ----------------------------------------------------------------------------
module led_logic_seq #(
  parameter int WIDTH = 4,
  parameter int DIV   = 100_000_000
) (
  input  logic            i_clk,
  input  logic            i_rst,
  led_logic_seq_if.slave  bus
);

  localparam int             CW         = $clog2(DIV) + 1;
  localparam logic [CW-1:0]  PRESC_LAST = CW'(DIV - 1);

  // Registered state
  logic [WIDTH-1:0] r_y;
  logic [2:0]       r_op;
  logic             r_valid;
  logic [CW-1:0]    r_presc;
  logic [2:0]       r_scan_op;
  logic             r_auto_d;   // i_auto as seen last cycle, for mode-change detect
`ifdef LED_ZERO_FLAG_EN
  logic             r_zero;
`endif

  // Combinational
  logic             w_mode_change;
  logic             w_tick;
  logic             w_ready;
  logic             w_accept;
  logic             w_load;
  logic [2:0]       w_op_sel;
  logic [WIDTH-1:0] w_result;

  function automatic logic bit_op(input logic [2:0] op, input logic a, input logic b);
    logic r;
    r = 1'b0;
    case (op)
      3'd0:    r = a & b;
      3'd1:    r = ~(a & b);
      3'd2:    r = a | b;
      3'd3:    r = ~(a | b);
      3'd4:    r = a ^ b;
      3'd5:    r = ~(a ^ b);
      3'd6:    r = ~a;
      default: r = a;
    endcase
    return r;
  endfunction

  assign w_mode_change = bus.i_auto ^ r_auto_d;

  // The mode-change cycle freezes everything: no tick, no accept. Keeping
  // o_ready low there means a request is never silently dropped.
  assign w_tick   = bus.i_auto & ~w_mode_change & (r_presc == PRESC_LAST);
  assign w_ready  = ~bus.i_auto & ~w_mode_change & (~r_valid | bus.i_ready);
  assign w_accept = bus.i_valid & w_ready;
  assign w_load   = w_tick | w_accept;
  assign w_op_sel = bus.i_auto ? r_scan_op : bus.i_op;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign w_result[gi] = bit_op(w_op_sel, bus.i_a[gi], bus.i_b[gi]);
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_y       <= '0;
      r_op      <= '0;
      r_valid   <= 1'b0;
      r_presc   <= '0;
      r_scan_op <= '0;
      // Track the live mode so leaving reset is not treated as a mode change.
      r_auto_d  <= bus.i_auto;
`ifdef LED_ZERO_FLAG_EN
      r_zero    <= 1'b0;
`endif
    end else begin
      r_auto_d <= bus.i_auto;

      if (w_mode_change) begin
        r_presc   <= '0;
        r_scan_op <= '0;
        r_valid   <= 1'b0;
      end else if (bus.i_auto) begin
        if (w_tick) begin
          r_presc   <= '0;
          r_scan_op <= r_scan_op + 3'd1;
        end else begin
          r_presc   <= r_presc + 1'b1;
        end
        // One-cycle pulse per tick.
        r_valid <= w_tick;
      end else if (w_accept) begin
        r_valid <= 1'b1;
      end else if (bus.i_ready) begin
        r_valid <= 1'b0;
      end

      if (w_load) begin
        r_y  <= w_result;
        r_op <= w_op_sel;
`ifdef LED_ZERO_FLAG_EN
        r_zero <= (w_result == '0);
`endif
      end
    end
  end

  assign bus.o_ready = w_ready;
  assign bus.o_y     = r_y;
  assign bus.o_op    = r_op;
  assign bus.o_valid = r_valid;
`ifdef LED_ZERO_FLAG_EN
  assign bus.o_zero  = r_zero;
`endif

endmodule
